fpu_div: RTL and testbench
==========================

# fpu_div

Multi-cycle floating-point divider that sits beside the combinational FPU and supplies the inverse of its multiply path. It divides half-precision (binary16) or single-precision (binary32) operands using a restoring, one-quotient-bit-per-cycle datapath. Requests use a start/busy/done handshake, and the block reports NZCV flags in the same layout as the FPU, so the core can treat a divide as a stalled FPU operation.

## Interface
- Parameters: none. Operand widths are fixed to binary16 and binary32 and are selected per request.
- clk  input  1  single clock; every register updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; reset is in effect while low.
- start  input  1  request strobe; sampled only in IDLE.
- Precision  input  1  operand format. 0 selects half, using only a[15:0] and b[15:0]. 1 selects single. Same encoding as FPUControl[1].
- a  input  32  dividend.
- b  input  32  divisor.
- busy  output  1  high from the edge that accepts start until the edge that asserts done.
- done  output  1  one-cycle pulse; Result and FPUFlags are valid while it is high.
- Result  output  32  quotient. For half requests, Result[31:16] is 0.
- FPUFlags  output  4  {N,Z,C,V}.

## Operation
- **States:** IDLE → UNPACK → DIVIDE → PACK → IDLE.
- **IDLE:**
  - If start=1, register a, b and Precision, set busy=1 and go to UNPACK.
  - start is ignored in every other state; it is never queued.
- **UNPACK:**
  - Split each operand into sign, exponent and mantissa. Let E=8 and M=23 for single, E=5 and M=10 for half.
  - Form the (M+1)-bit significands ma and mb with the hidden 1.
  - An exponent of 0 means zero: denormals are flushed to zero.
  - An exponent of all ones means inf/NaN.
  - Classify the request as a special case (below) or normal.
  - Compute the signed exponent ed = ea − eb + bias, held in E+2 bits.
  - Set the result sign s = sa XOR sb.
- **DIVIDE:** runs exactly M+2 cycles, including for special cases, so latency is fixed.
  - Each cycle produces one bit of Q = floor((ma << (M+1)) / mb), MSB first, by restoring subtraction.
  - The partial remainder register is M+3 bits wide.
- **PACK:**
  - If Q[M+1]=1: mantissa = Q[M:1], exponent = ed.
  - If Q[M+1]=0: mantissa = Q[M−1:0], exponent = ed−1.
  - Rounding is truncation (toward zero).
  - Exponent ≥ 2^E−1 → overflow: result is signed infinity, V=1.
  - Exponent ≤ 0 → underflow: result is signed zero, Z=1.
  - Result and FPUFlags are registered, done=1, busy=0, next state IDLE.
- **Special cases**, resolved in PACK with higher priority than normal packing:
  - Either operand is inf/NaN, or both operands are zero → canonical NaN (0x7FC00000 single, 0x7E00 half), N=0, V=1.
  - b is zero and a is nonzero → signed infinity, V=1.
  - a is zero and b is nonzero → signed zero, Z=1.
- **Flags:**
  - N = sign bit of Result.
  - Z = exponent and mantissa fields of Result are all zero.
  - C = 0 always.
  - V = overflow, divide-by-zero or NaN.
- Result and FPUFlags hold their values until the next PACK.

## Timing
- **Reset values:** busy=0, done=0, Result=0, FPUFlags=0, state IDLE.
- **Latency:** start is accepted at edge t; done is asserted after edge t+M+4.
  - Single: done is high in the cycle after edge t+27.
  - Half: done is high in the cycle after edge t+14.
- **Back-to-back requests:** start may be high in the same cycle done is high; that request is accepted on the following edge, because the state is already IDLE. Throughput is one divide per M+5 cycles.
- Operand inputs may change freely after the accepting edge.
- **Reset during an operation:** the block returns to IDLE immediately. No done pulse is produced and Result reverts to 0.

## Test plan
- **Single, normal:** a=0x40C00000 (6.0), b=0x40000000 (2.0) → Result=0x40400000, NZCV=0000; done exactly 27 cycles after the start edge, busy low in the same cycle.
- **Half with truncation:** a=0x3C00 (1.0), b=0x4200 (3.0), Precision=0 → Result=0x00003555, NZCV=0000, 14-cycle latency.
- **Divide by zero and NaN:**
  - a=0xBF800000, b=0 → Result=0xFF800000, NZCV=1001.
  - a=0, b=0 → Result=0x7FC00000, NZCV=0001.
- **Exponent range:**
  - a=0x7F000000, b=0x3E800000 → Result=0x7F800000, V=1.
  - a=0x00800000, b=0x40000000 → Result=0x00000000, NZCV=0100.
- **Handshake:**
  - A start pulse in mid-DIVIDE is ignored and yields a single done.
  - start held high through done launches the next divide on the following edge.
- **Reset:** drive reset low at cycle 10 of a single divide → busy, done and Result are 0 immediately, and no done pulse follows; a new divide after reset releases completes normally.

Source files
------------

// File: rtl/fpu_div.sv
`timescale 1ns/1ps
// fpu_div: multi-cycle restoring divider for binary16/binary32 operands with FPU-style NZCV flags.
// Latency is fixed at M+4 edges from start acceptance to done, special cases included.
module fpu_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        Precision,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] Result,
    output logic [3:0]  FPUFlags
);
    typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_PACK} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_busy, w_accept, w_unpack, w_divide, w_pack;

    logic              r_prec;
    logic [31:0]       r_a, r_b;
    logic              r_sign, r_nan, r_inf, r_zero;
    logic signed [9:0] r_ed;
    logic [23:0]       r_mb;
    logic [25:0]       r_rem;
    logic [24:0]       r_q;
    logic [4:0]        r_cnt;
    logic              r_done;
    logic [31:0]       r_result;
    logic [3:0]        r_flags;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_UNPACK;
            S_UNPACK: w_next = S_DIVIDE;
            S_DIVIDE: if (r_cnt == 5'd0) w_next = S_PACK;
            S_PACK:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state != S_IDLE);
        w_accept = (r_state == S_IDLE) && start;
        w_unpack = (r_state == S_UNPACK);
        w_divide = (r_state == S_DIVIDE);
        w_pack   = (r_state == S_PACK);
    end

    // Operand field extraction; half operands are widened into the single-precision layout
    logic              w_sa, w_sb, w_ea_zero, w_eb_zero, w_ea_max, w_eb_max;
    logic [7:0]        w_ea, w_eb;
    logic [23:0]       w_ma, w_mb;
    logic signed [9:0] w_ed;

    always_comb begin
        if (r_prec) begin
            w_sa     = r_a[31];
            w_ea     = r_a[30:23];
            w_ma     = {1'b1, r_a[22:0]};
            w_ea_max = &r_a[30:23];
            w_sb     = r_b[31];
            w_eb     = r_b[30:23];
            w_mb     = {1'b1, r_b[22:0]};
            w_eb_max = &r_b[30:23];
        end else begin
            w_sa     = r_a[15];
            w_ea     = {3'b000, r_a[14:10]};
            w_ma     = {13'd0, 1'b1, r_a[9:0]};
            w_ea_max = &r_a[14:10];
            w_sb     = r_b[15];
            w_eb     = {3'b000, r_b[14:10]};
            w_mb     = {13'd0, 1'b1, r_b[9:0]};
            w_eb_max = &r_b[14:10];
        end
        w_ea_zero = (w_ea == 8'd0);
        w_eb_zero = (w_eb == 8'd0);
        w_ed      = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb})
                  + (r_prec ? 10'sd127 : 10'sd15);
    end

    logic              w_ge;
    logic [25:0]       w_diff;

    assign w_ge   = (r_rem >= {2'b00, r_mb});
    assign w_diff = r_rem - {2'b00, r_mb};

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_prec <= Precision;
        end
        if (w_unpack) begin
            r_sign <= w_sa ^ w_sb;
            r_nan  <= w_ea_max | w_eb_max | (w_ea_zero & w_eb_zero);
            r_inf  <= w_eb_zero & ~w_ea_zero;
            r_zero <= w_ea_zero & ~w_eb_zero;
            r_ed   <= w_ed;
            r_mb   <= w_mb;
            r_rem  <= {2'b00, w_ma};
            r_q    <= '0;
            r_cnt  <= r_prec ? 5'd24 : 5'd11;
        end
        if (w_divide) begin
            r_rem <= (w_ge ? w_diff : r_rem) << 1;
            r_q   <= {r_q[23:0], w_ge};
            r_cnt <= r_cnt - 5'd1;
        end
    end

    // Normalisation, range checks and special-case priority
    logic              w_qtop, w_ovf, w_unf, w_v, w_n, w_z;
    logic [22:0]       w_mant;
    logic signed [9:0] w_exp, w_emax;
    logic [31:0]       w_res;

    always_comb begin
        if (r_prec) begin
            w_qtop = r_q[24];
            w_mant = w_qtop ? r_q[23:1] : r_q[22:0];
            w_emax = 10'sd255;
        end else begin
            w_qtop = r_q[11];
            w_mant = {13'd0, (w_qtop ? r_q[10:1] : r_q[9:0])};
            w_emax = 10'sd31;
        end
        w_exp = w_qtop ? r_ed : (r_ed - 10'sd1);
        w_ovf = (w_exp >= w_emax);
        w_unf = (w_exp <= 10'sd0);
        w_v   = 1'b0;
        if (r_nan) begin
            w_res = r_prec ? 32'h7FC0_0000 : 32'h0000_7E00;
            w_v   = 1'b1;
        end else if (r_inf) begin
            w_res = r_prec ? {r_sign, 8'hFF, 23'd0} : {16'd0, r_sign, 5'h1F, 10'd0};
            w_v   = 1'b1;
        end else if (r_zero) begin
            w_res = r_prec ? {r_sign, 31'd0} : {16'd0, r_sign, 15'd0};
        end else if (w_ovf) begin
            w_res = r_prec ? {r_sign, 8'hFF, 23'd0} : {16'd0, r_sign, 5'h1F, 10'd0};
            w_v   = 1'b1;
        end else if (w_unf) begin
            w_res = r_prec ? {r_sign, 31'd0} : {16'd0, r_sign, 15'd0};
        end else begin
            w_res = r_prec ? {r_sign, w_exp[7:0], w_mant}
                           : {16'd0, r_sign, w_exp[4:0], w_mant[9:0]};
        end
        w_n = r_prec ? w_res[31] : w_res[15];
        w_z = r_prec ? (w_res[30:0] == 31'd0) : (w_res[14:0] == 15'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done   <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_done <= w_pack;
            if (w_pack) begin
                r_result <= w_res;
                r_flags  <= {w_n, w_z, 1'b0, w_v};
            end
        end
    end

    assign busy     = w_busy;
    assign done     = r_done;
    assign Result   = r_result;
    assign FPUFlags = r_flags;
endmodule

// File: tb/tb_fpu_div.sv
`timescale 1ns/1ps
// tb_fpu_div: directed and randomized checks of fpu_div against an integer-arithmetic reference model.
module tb_fpu_div;
    logic        clk = 1'b0;
    logic        reset, start, Precision;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] Result;
    logic [3:0]  FPUFlags;
    int          errors = 0;
    int          checks = 0;

    fpu_div dut (
        .clk(clk), .reset(reset), .start(start), .Precision(Precision),
        .a(a), .b(b), .busy(busy), .done(done), .Result(Result), .FPUFlags(FPUFlags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Quotient value from the format rules: exact integer divide, truncate, range-check.
    function automatic void model(input bit prec, input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] res, output logic [3:0] fl);
        longint one, E, M, bias, emax, mask, sa, sb, ea, eb, ma, mb, q, ex, mant, s, r, aa, bb;
        bit     v, nb, zb;
        one  = 1;
        E    = prec ? 8 : 5;
        M    = prec ? 23 : 10;
        bias = (one << (E - 1)) - 1;
        emax = (one << E) - 1;
        mask = (one << M) - 1;
        aa   = longint'(av);
        bb   = longint'(bv);
        sa   = (aa >> (E + M)) & 1;
        sb   = (bb >> (E + M)) & 1;
        ea   = (aa >> M) & emax;
        eb   = (bb >> M) & emax;
        s    = sa ^ sb;
        v    = 1'b0;
        if (ea == emax || eb == emax || (ea == 0 && eb == 0)) begin
            r = prec ? 64'h7FC0_0000 : 64'h7E00;
            v = 1'b1;
        end else if (eb == 0) begin
            r = (s << (E + M)) | (emax << M);
            v = 1'b1;
        end else if (ea == 0) begin
            r = s << (E + M);
        end else begin
            ma = (aa & mask) | (one << M);
            mb = (bb & mask) | (one << M);
            q  = (ma << (M + 1)) / mb;
            ex = ea - eb + bias;
            if (q >= (one << (M + 1))) mant = (q >> 1) & mask;
            else begin
                mant = q & mask;
                ex   = ex - 1;
            end
            if (ex >= emax) begin
                r = (s << (E + M)) | (emax << M);
                v = 1'b1;
            end else if (ex <= 0) r = s << (E + M);
            else r = (s << (E + M)) | (ex << M) | mant;
        end
        nb  = ((r >> (E + M)) & 1) != 0;
        zb  = (r & ((one << (E + M)) - 1)) == 0;
        res = 32'(r);
        fl  = {nb, zb, 1'b0, v};
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_div(input bit prec, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] er, input logic [3:0] ef, input string tag);
        int n;
        @(negedge clk);
        start = 1'b1; Precision = prec; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; Precision = ~prec;
        chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
        wait_done(n);
        chk({tag, "_latency"}, n, prec ? 32'd27 : 32'd14);
        chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
        chk({tag, "_result"}, Result, er);
        chk({tag, "_flags"}, 32'(FPUFlags), 32'(ef));
    endtask

    initial begin
        logic [31:0] av, bv, er;
        logic [3:0]  ef;
        bit          prec;
        int          n, extra;

        reset = 1'b0; start = 1'b0; Precision = 1'b0; a = '0; b = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_flags", 32'(FPUFlags), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        do_div(1'b1, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, "s_6div2");
        do_div(1'b0, 32'h0000_3C00, 32'h0000_4200, 32'h0000_3555, 4'b0000, "h_1div3");
        do_div(1'b1, 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 4'b1001, "s_div0");
        do_div(1'b1, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0001, "s_0div0");
        do_div(1'b1, 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 4'b0001, "s_ovf");
        do_div(1'b1, 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0100, "s_unf");
        do_div(1'b1, 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 4'b1100, "s_negzero");
        do_div(1'b0, 32'h0000_7C00, 32'h0000_3C00, 32'h0000_7E00, 4'b0001, "h_inf_nan");
        do_div(1'b0, 32'h0000_3C00, 32'h0000_0000, 32'h0000_7C00, 4'b0001, "h_div0");
        do_div(1'b0, 32'h0000_C600, 32'h0000_4000, 32'h0000_C200, 4'b1000, "h_neg");

        // start pulsed mid-divide must be ignored
        @(negedge clk);
        start = 1'b1; Precision = 1'b0; a = 32'h0000_4500; b = 32'h0000_4000;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
            start = (n == 5);
            if (n == 5) begin a = 32'h0000_3C00; b = 32'h0000_0000; end
        end
        start = 1'b0;
        chk("ign_latency", n, 32'd14);
        chk("ign_result", Result, 32'h0000_4100);
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        chk("ign_no_extra_done", extra, 32'd0);

        // start held high through done launches the next divide on the following edge
        @(negedge clk);
        start = 1'b1; Precision = 1'b1; a = 32'h4120_0000; b = 32'h4080_0000;
        @(posedge clk); #1;
        a = 32'h3F80_0000; b = 32'h4040_0000;
        wait_done(n);
        chk("b2b_lat1", n, 32'd27);
        chk("b2b_res1", Result, 32'h4020_0000);
        @(posedge clk); #1;
        chk("b2b_busy2", 32'(busy), 32'd1);
        chk("b2b_done_lo", 32'(done), 32'd0);
        start = 1'b0;
        wait_done(n);
        chk("b2b_lat2", n, 32'd27);
        chk("b2b_res2", Result, 32'h3EAA_AAAA);
        chk("b2b_flags2", 32'(FPUFlags), 32'd0);

        for (int i = 0; i < 24; i++) begin
            prec = i[0];
            av = $urandom;
            bv = $urandom;
            if (i % 4 != 3) begin
                if (prec) begin
                    av[30:23] = 8'($urandom_range(64, 190));
                    bv[30:23] = 8'($urandom_range(64, 190));
                end else begin
                    av[14:10] = 5'($urandom_range(1, 30));
                    bv[14:10] = 5'($urandom_range(1, 30));
                end
            end
            model(prec, av, bv, er, ef);
            do_div(prec, av, bv, er, ef, $sformatf("rnd%0d", i));
        end

        // reset in the middle of a single divide
        do_div(1'b0, 32'h0000_C600, 32'h0000_4000, 32'h0000_C200, 4'b1000, "pre_rst");
        @(negedge clk);
        start = 1'b1; Precision = 1'b1; a = 32'h40C0_0000; b = 32'h4000_0000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_result", Result, 32'd0);
        chk("mid_rst_flags", 32'(FPUFlags), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        extra = 0;
        repeat (35) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        chk("mid_rst_no_done", extra, 32'd0);
        do_div(1'b1, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
